// File: rtl/dbf_fine_apo.sv
// Per-channel fine-delay (linear interpolation) and apodisation stage.
// Ports: clk, rst_n (sync, active-high), tx_en, start, fd_din/_valid,
//   apo_din, lut_addr/lut_we/lut_wdata -> fd_dout/_valid, busy, line_done.
module dbf_fine_apo #(
    parameter int INPUT_WD    = 14,
    parameter int APO_WD      = 16,
    parameter int FRAC_WD     = 8,
    parameter int ADDR_WD     = 12,
    parameter int NUM_SAMPLES = 4096,
    parameter int OUT_WD      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_en,
    input  logic                       start,
    input  logic signed [INPUT_WD-1:0] fd_din,
    input  logic                       fd_din_valid,
    input  logic signed [APO_WD-1:0]   apo_din,
    input  logic [ADDR_WD-1:0]         lut_addr,
    input  logic                       lut_we,
    input  logic [FRAC_WD-1:0]         lut_wdata,
    output logic [OUT_WD-1:0]          fd_dout,
    output logic                       fd_dout_valid,
    output logic                       busy,
    output logic                       line_done
);
    localparam int D_WD = INPUT_WD + 1;
    localparam int M_WD = D_WD + FRAC_WD + 1;
    localparam int P_WD = INPUT_WD + APO_WD;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [FRAC_WD-1:0]         lut [2**ADDR_WD];
    logic [ADDR_WD-1:0]         index;
    logic signed [INPUT_WD-1:0] prev;
    logic accept, abort, last, line_start;

    logic signed [INPUT_WD-1:0] x1, p1, x2, f3;
    logic signed [APO_WD-1:0]   a1, a2, a3;
    logic [FRAC_WD-1:0]         fr1;
    logic signed [M_WD-1:0]     m2;
    logic v1, v2, v3;

    logic signed [D_WD-1:0]     diff;
    logic signed [M_WD-1:0]     m_full;
    logic signed [INPUT_WD-1:0] f_sum;
    logic signed [P_WD-1:0]     prod;

    assign last = (index == ADDR_WD'(NUM_SAMPLES - 1));
    assign busy = (state == RUN);

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        abort      = 1'b0;
        line_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    line_start = 1'b1;
                end
            end
            RUN: begin
                if (!start) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end else if (fd_din_valid && !tx_en) begin
                    accept = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LUT is only writable while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n && lut_we && state == IDLE)
            lut[lut_addr] <= lut_wdata;
    end

    // Interpolation: f = x + floor((p - x) * frac / 2^FRAC_WD).
    assign diff   = D_WD'(p1) - D_WD'(x1);
    assign m_full = diff * $signed({1'b0, fr1});
    assign f_sum  = x2 + INPUT_WD'(m2 >>> FRAC_WD);
    assign prod   = f3 * a3;

    // Datapath registers carry no reset; the valid chain qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            x1  <= fd_din;
            p1  <= prev;
            a1  <= apo_din;
            fr1 <= lut[index];
        end
        m2 <= m_full;
        x2 <= x1;
        a2 <= a1;
        f3 <= f_sum;
        a3 <= a2;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= IDLE;
            index         <= '0;
            prev          <= '0;
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            fd_dout_valid <= 1'b0;
            fd_dout       <= '0;
            line_done     <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_done <= accept && last;
            if (line_start) begin
                index <= '0;
                prev  <= '0;
            end else if (accept) begin
                prev <= fd_din;
                if (!last) index <= index + 1'b1;
            end
            // Abort flushes every in-flight sample on the same edge.
            v1            <= accept;
            v2            <= v1 && !abort;
            v3            <= v2 && !abort;
            fd_dout_valid <= v3 && !abort;
            if (v3 && !abort)
                fd_dout <= {{(OUT_WD - P_WD){prod[P_WD-1]}}, prod};
            else
                fd_dout <= '0;
        end
    end
endmodule

// File: tb/tb_dbf_fine_apo.sv
// Self-checking bench for dbf_fine_apo: spec-level model plus directed
// vectors with hand-computed literal outputs.
module tb_dbf_fine_apo;
    localparam int NS = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tx_en;
    logic               start;
    logic signed [13:0] fd_din;
    logic               fd_din_valid;
    logic signed [15:0] apo_din;
    logic [11:0]        lut_addr;
    logic               lut_we;
    logic [7:0]         lut_wdata;
    logic [31:0]        fd_dout;
    logic               fd_dout_valid;
    logic               busy;
    logic               line_done;

    dbf_fine_apo #(.NUM_SAMPLES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
        .fd_din(fd_din), .fd_din_valid(fd_din_valid), .apo_din(apo_din),
        .lut_addr(lut_addr), .lut_we(lut_we), .lut_wdata(lut_wdata),
        .fd_dout(fd_dout), .fd_dout_valid(fd_dout_valid),
        .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     due;
        longint val;
    } exp_t;

    exp_t   q[$];
    int     cyc = 0;
    int     mode = 0;          // 0 idle, 1 run, 2 done
    int     idx = 0;
    int     prv = 0;
    int     ld_cyc = -100;
    int     mlut [NS];
    bit     chk_en = 0;

    function automatic longint interp(int x, int p, int fr, int apo);
        int dd, qq;
        dd = (p - x) * fr;
        qq = dd / 256;
        if (dd < 0 && dd % 256 != 0) qq--;
        return longint'(x + qq) * apo;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            mode = 0;
            q.delete();
            ld_cyc = -100;
        end else begin
            if (lut_we && mode == 0 && lut_addr < NS)
                mlut[lut_addr] = int'(lut_wdata);
            case (mode)
                0: if (start) begin
                    mode = 1; idx = 0; prv = 0;
                end
                1: if (!start) begin
                    mode = 0;
                    q.delete();
                end else if (fd_din_valid && !tx_en) begin
                    q.push_back('{cyc + 3,
                        interp(int'(fd_din), prv, mlut[idx], int'(apo_din))});
                    prv = int'(fd_din);
                    if (idx == NS - 1) begin
                        mode = 2;
                        ld_cyc = cyc;
                    end else idx++;
                end
                default: if (!start) mode = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    longint seen[$];
    int     ld_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit ev;
            longint evl;
            ev  = (q.size() > 0 && q[0].due == cyc);
            evl = ev ? q[0].val : 0;
            chk("valid", longint'(fd_dout_valid), longint'(ev));
            chk("dout", longint'($signed(fd_dout)), evl);
            chk("busy", longint'(busy), longint'(mode == 1));
            chk("line_done", longint'(line_done), longint'(ld_cyc == cyc));
            if (ev) void'(q.pop_front());
        end
        if (fd_dout_valid === 1'b1) seen.push_back(longint'($signed(fd_dout)));
        if (line_done === 1'b1) ld_count++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(int x);
        fd_din = 14'(x);
        fd_din_valid = 1'b1;
        tick();
        fd_din_valid = 1'b0;
    endtask

    task automatic lut_wr(int a, int d);
        lut_addr = 12'(a);
        lut_wdata = 8'(d);
        lut_we = 1'b1;
        tick();
        lut_we = 1'b0;
    endtask

    task automatic begin_line();
        seen.delete();
        start = 1'b1;
        tick();
    endtask

    task automatic end_line();
        start = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b1; tx_en = 1'b0; start = 1'b1;
        fd_din = '0; fd_din_valid = 1'b1; apo_din = '0;
        lut_addr = '0; lut_we = 1'b0; lut_wdata = '0;
        tick();
        chk_en = 1;
        tick(2);
        rst_n = 1'b0; start = 1'b0; fd_din_valid = 1'b0;
        chk("rst_dout", longint'(fd_dout), 0);
        chk("rst_busy", longint'(busy), 0);

        for (int k = 0; k < NS; k++) lut_wr(k, 30 * k);
        lut_wr(0, 128);
        lut_wr(1, 64);
        // LUT must survive a second reset
        rst_n = 1'b1;
        tick(3);
        rst_n = 1'b0;

        // interpolation against prev=0, then prev=1000
        begin_line();
        apo_din = 16'sd1;
        feed(1000);
        feed(2000);
        tick(6);
        chk("interp_n", seen.size(), 2);
        chk("interp_0", seen.size() > 0 ? seen[0] : 0, 500);
        chk("interp_1", seen.size() > 1 ? seen[1] : 0, 1750);
        end_line();

        // zero fraction
        for (int k = 0; k < 3; k++) lut_wr(k, 0);
        begin_line();
        apo_din = 16'sd16384;
        feed(100);
        feed(-200);
        feed(300);
        tick(6);
        chk("zero_n", seen.size(), 3);
        chk("zero_0", seen.size() > 0 ? seen[0] : 0, 1638400);
        chk("zero_1", seen.size() > 1 ? seen[1] : 0, -3276800);
        chk("zero_2", seen.size() > 2 ? seen[2] : 0, 4915200);
        end_line();

        // floor of a negative result
        lut_wr(0, 255);
        begin_line();
        apo_din = 16'sd1;
        feed(-1);
        tick(6);
        chk("neg_n", seen.size(), 1);
        chk("neg_0", seen.size() > 0 ? seen[0] : 0, -1);
        end_line();

        // tx_en gating
        for (int k = 0; k < NS; k++) lut_wr(k, 30 * k);
        begin_line();
        apo_din = 16'sd2;
        feed(100);
        feed(200);
        tx_en = 1'b1;
        repeat (5) feed(999);
        tx_en = 1'b0;
        feed(400);
        tick(6);
        chk("gate_n", seen.size(), 3);
        chk("gate_0", seen.size() > 0 ? seen[0] : 0, 200);
        chk("gate_1", seen.size() > 1 ? seen[1] : 0, 376);
        chk("gate_2", seen.size() > 2 ? seen[2] : 0, 706);
        end_line();

        // line end
        begin_line();
        ld_count = 0;
        apo_din = 16'sd1;
        for (int i = 0; i < 10; i++) feed(10 * i + 5);
        tick(6);
        chk("line_n", seen.size(), NS);
        chk("line_done_n", ld_count, 1);
        chk("line_busy", longint'(busy), 0);
        end_line();
        begin_line();
        feed(-50);
        tick(6);
        chk("restart_n", seen.size(), 1);
        chk("restart_0", seen.size() > 0 ? seen[0] : 0, -50);
        end_line();

        // abort flushes in-flight samples
        begin_line();
        feed(300);
        feed(301);
        start = 1'b0;
        tick(6);
        chk("abort_n", seen.size(), 0);

        // reset mid-line flushes in-flight samples
        begin_line();
        feed(300);
        feed(301);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        start = 1'b0;
        tick(6);
        chk("midrst_n", seen.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dbf_fine_apo.md
Name: dbf_fine_apo

Overview:
- Per-channel fine-delay and apodisation stage. Sits directly downstream of the per-channel coarse-delay LUT stage and consumes its delayed sample stream.
- Applies a per-sample fractional delay by linear interpolation between the current and previous coarse-delayed samples. The fractional weight comes from a loadable on-chip LUT.
- Multiplies the interpolated sample by the apodisation weight and presents a registered 32-bit result to the channel summer.

Parameters:
- INPUT_WD, 14, width of signed coarse-delayed input sample
- APO_WD, 16, width of signed apodisation weight
- FRAC_WD, 8, width of unsigned fractional-delay weight (LSB = 1/256 sample)
- ADDR_WD, 12, fine-delay LUT address width
- NUM_SAMPLES, 4096, samples per receive line (at most 2^ADDR_WD)
- OUT_WD, 32, output width

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, reset: synchronous, active-high (asserted when 1)
- tx_en, in, 1, transmit active; while 1, input samples are not accepted
- start, in, 1, level: line acquisition enable
- fd_din, in, INPUT_WD, signed coarse-delayed sample
- fd_din_valid, in, 1, fd_din qualifier
- apo_din, in, APO_WD, signed apodisation weight, sampled together with fd_din
- lut_addr, in, ADDR_WD, fine LUT write address
- lut_we, in, 1, fine LUT write enable
- lut_wdata, in, FRAC_WD, fine LUT write data (unsigned fraction)
- fd_dout, out, OUT_WD, signed apodised output
- fd_dout_valid, out, 1, fd_dout qualifier
- busy, out, 1, high in RUN
- line_done, out, 1, one-cycle pulse when the NUM_SAMPLES-th sample is accepted

Behaviour:
- Reset (rst_n=1 at clk edge): state=IDLE; fd_dout=0, fd_dout_valid=0, busy=0, line_done=0; prev sample=0, sample index=0, pipeline valids=0. LUT contents are not cleared.
- States:
  - IDLE: start=1 -> RUN; on this transition clear the prev register and the index.
  - RUN: start=0 -> IDLE (abort). Index reaches NUM_SAMPLES-1 on an accepted sample -> DONE.
  - DONE: start=0 -> IDLE.
- Accept condition: state==RUN & fd_din_valid & ~tx_en. Samples arriving in IDLE or DONE, or while tx_en=1, are dropped.
- LUT write rules:
  - A write occurs only when lut_we=1 and state==IDLE. Writes in RUN or DONE are ignored.
  - LUT read is synchronous, addressed by the sample index.
- Pipeline, with the sample accepted at cycle T:
  - T+1: capture x=fd_din, p=prev, apo, frac=LUT[index]. prev<=fd_din. index increments (no wrap; stops at DONE).
  - T+2: d = p - x, width INPUT_WD+1 signed; m = d * frac, signed by unsigned.
  - T+3: f = x + (m >>> FRAC_WD), arithmetic shift, truncation toward minus infinity. The result fits INPUT_WD because f lies between x and p.
  - T+4: fd_dout = sign-extended f*apo (INPUT_WD+APO_WD bits into OUT_WD); fd_dout_valid=1.
  - Latency: 4 cycles accepted-to-valid. Throughput: one sample per clock.
- Output when not valid: fd_dout=0, fd_dout_valid=0.
- First sample after start interpolates against prev=0.
- frac=0 gives f=x exactly. frac=255 gives f = x + floor(255*(p-x)/256).
- line_done is asserted in the cycle after the last sample is accepted (T+1). The in-flight samples still drain normally.
- Abort (start falls in RUN): pipeline valids cleared on the same edge; no further outputs.
- rst_n mid-operation: all pipeline contents discarded; outputs 0 on the following cycle.
- Simultaneous events:
  - tx_en=1 with fd_din_valid=1: no accept, index unchanged.
  - lut_we in the same cycle as the IDLE->RUN transition: the write is performed.

Test Plan:
- Reset: hold rst_n=1 for 3 clk with fd_din_valid=1, start=1 -> fd_dout=0, fd_dout_valid=0, busy=0 throughout; LUT readback unchanged.
- Zero fraction: LUT all 0, apo=16384, start=1, feed fd_din=100,-200,300 -> four cycles later fd_dout=1638400,-3276800,4915200 on consecutive cycles, valid=1 each.
- Interpolation: LUT[0]=128, LUT[1]=64, apo=1, feed 1000 then 2000 -> outputs 500 (prev 0), then 1750.
- Negative rounding: LUT[0]=255, apo=1, prev=0, x=-1 -> f=-1+floor(255/256)=-1, so fd_dout=-1 (all ones, 32 bits).
- Gating: in RUN assert tx_en=1 for 5 valid samples, then release -> no outputs during tx_en; index not advanced, so the next accepted sample uses LUT[k].
- Line end: NUM_SAMPLES=8, feed 10 samples -> exactly 8 outputs; line_done pulses once, 1 cycle after the 8th accept. busy falls at that point. start=0 then 1 restarts at index 0.
